dmem_responder: RTL and testbench

- Data-memory responder for the pipelined 8-bit datapath. It sits on the far side of the MEM-stage load/store interface.
- Accepts one load or store request at a time over a valid/ready handshake and performs it on internal 256x8 storage after a programmable latency.
- Returns a one-cycle response pulse and drives a stall so the pipeline holds its stage-3/stage-4 latches while the access is in flight.

---
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time on a 2^ADDR_W x DATA_W store,
// completing LATENCY cycles after acceptance with a one-cycle response pulse.
//
// state  | meaning
// S_IDLE | ready; a valid request is accepted on the next edge
// S_WAIT | latency down-counter running; access happens when it reaches zero
// S_RESP | rsp_valid pulse; back to S_IDLE on the next edge
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic              stall
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_accept;
    logic                w_access;

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_access  = (r_state == S_WAIT) && (r_cnt == 4'd0);

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign stall     = req_valid && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_write <= req_write;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Stores echo their own data so the response path is shared with loads.
            if (w_access) begin
                rsp_rdata <= r_write ? r_wdata : r_mem[r_addr];
                rsp_write <= r_write;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_access && r_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) checked every cycle
// against a timeline model (accept edge k -> access at k+L, ready again after k+L+1).
module tb_dmem_responder;

    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{2, 1, 15};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid [NDUT];
    logic       req_write [NDUT];
    logic [7:0] req_addr  [NDUT];
    logic [7:0] req_wdata [NDUT];
    logic       req_ready [NDUT];
    logic       rsp_valid [NDUT];
    logic [7:0] rsp_rdata [NDUT];
    logic       rsp_write [NDUT];
    logic       stall     [NDUT];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            dmem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(LATS[g])) u_dut (
                .clk       (clk),
                .rst       (rst),
                .req_valid (req_valid[g]),
                .req_write (req_write[g]),
                .req_addr  (req_addr[g]),
                .req_wdata (req_wdata[g]),
                .req_ready (req_ready[g]),
                .rsp_valid (rsp_valid[g]),
                .rsp_rdata (rsp_rdata[g]),
                .rsp_write (rsp_write[g]),
                .stall     (stall[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_vec++;
        n_fail++;
        $display("FAIL %s: no DUT event within cycle budget at %0t", nm, $time);
    endtask

    // Behavioural model: timeline per instance plus a plain array memory.
    int         e_cnt = 0;
    int         resp_e     [NDUT] = '{-100, -100, -100};
    int         busy_until [NDUT] = '{-100, -100, -100};
    logic       m_w [NDUT];
    logic [7:0] m_a [NDUT];
    logic [7:0] m_d [NDUT];
    logic [7:0] exp_rdata [NDUT] = '{8'h00, 8'h00, 8'h00};
    logic       exp_write [NDUT] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] mmem [NDUT][256];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NDUT; i++) begin
                resp_e[i]     = -100;
                busy_until[i] = -100;
                exp_rdata[i]  = 8'h00;
                exp_write[i]  = 1'b0;
                for (int j = 0; j < 256; j++) mmem[i][j] = 8'h00;
            end
        end else begin
            e_cnt++;
            for (int i = 0; i < NDUT; i++) begin
                if (e_cnt == resp_e[i]) begin
                    if (m_w[i]) mmem[i][m_a[i]] = m_d[i];
                    exp_rdata[i] = mmem[i][m_a[i]];
                    exp_write[i] = m_w[i];
                end
                if (e_cnt - 1 >= busy_until[i] && req_valid[i]) begin
                    resp_e[i]     = e_cnt + LATS[i];
                    busy_until[i] = e_cnt + LATS[i] + 1;
                    m_w[i] = req_write[i];
                    m_a[i] = req_addr[i];
                    m_d[i] = req_wdata[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            logic exp_ready;
            exp_ready = (e_cnt >= busy_until[i]);
            chk($sformatf("req_ready[%0d]", i), req_ready[i], exp_ready);
            chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], (e_cnt == resp_e[i]));
            chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], exp_rdata[i]);
            chk($sformatf("rsp_write[%0d]", i), rsp_write[i], exp_write[i]);
            chk($sformatf("stall[%0d]", i), stall[i], req_valid[i] & ~exp_ready);
        end
    end

    // Returns just after the accepting edge (+1) with ok set, or ok clear on timeout.
    task automatic wait_accept(input int i, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) timeout_fail($sformatf("accept[%0d]", i));
    endtask

    task automatic wait_rsp(input int i, output int lat, output logic [7:0] rd, output logic rw);
        lat = -1;
        rd  = 8'h00;
        rw  = 1'b0;
        for (int t = 0; t < 40 && lat < 0; t++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                lat = t;
                rd  = rsp_rdata[i];
                rw  = rsp_write[i];
            end
        end
        if (lat < 0) timeout_fail($sformatf("rsp[%0d]", i));
    endtask

    task automatic do_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] alt_a, output int lat, output logic [7:0] rd,
                          output logic rw);
        bit ok;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        wait_accept(i, ok);
        req_valid[i] = 1'b0;
        req_addr[i]  = alt_a;
        req_wdata[i] = 8'($urandom);
        req_write[i] = 1'($urandom);
        if (ok) wait_rsp(i, lat, rd, rw);
        else lat = -1;
    endtask

    task automatic rand_run(input int i, input int n);
        int         lat;
        logic [7:0] rd;
        logic       rw;
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            do_req(i, 1'($urandom), a, 8'($urandom), 8'($urandom), lat, rd, rw);
            chk($sformatf("rand_lat[%0d]", i), lat, LATS[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int         lat;
        int         n;
        bit         ok;
        logic [7:0] rd;
        logic       rw;

        for (int i = 0; i < NDUT; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 8'h00;
            req_wdata[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;

        @(negedge clk);
        chk("reset_ready", req_ready[0], 1);
        chk("reset_valid", rsp_valid[0], 0);
        chk("reset_rdata", rsp_rdata[0], 8'h00);
        chk("reset_stall", stall[0], 0);
        do_req(0, 1'b0, 8'h00, 8'h00, 8'h00, lat, rd, rw);
        chk("load0_rdata", rd, 8'h00);

        do_req(0, 1'b1, 8'h3C, 8'hA5, 8'h3C, lat, rd, rw);
        chk("st_a5_lat", lat, 2);
        chk("st_a5_rdata", rd, 8'hA5);
        chk("st_a5_write", rw, 1);
        @(negedge clk);
        chk("st_a5_ready_after", req_ready[0], 1);
        chk("st_a5_valid_after", rsp_valid[0], 0);

        // Back-to-back store then load with req_valid held high.
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 8'hFF;
        req_wdata[0] = 8'h5A;
        wait_accept(0, ok);
        req_write[0] = 1'b0;
        req_wdata[0] = 8'h00;
        n  = 0;
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                @(posedge clk);
                n++;
                ok = 1'b1;
            end else begin
                chk("b2b_stall", stall[0], 1);
                @(posedge clk);
                n++;
            end
        end
        #1;
        req_valid[0] = 1'b0;
        chk("b2b_gap", n, 4);
        wait_rsp(0, lat, rd, rw);
        chk("b2b_rdata", rd, 8'h5A);
        chk("b2b_write", rw, 0);

        // Address changes during WAIT must not affect the access.
        do_req(0, 1'b1, 8'h10, 8'h11, 8'h10, lat, rd, rw);
        do_req(0, 1'b1, 8'h20, 8'h22, 8'h20, lat, rd, rw);
        do_req(0, 1'b0, 8'h10, 8'h00, 8'h20, lat, rd, rw);
        chk("addr_change_rdata", rd, 8'h11);

        // Asynchronous reset in the middle of a store.
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 8'h05;
        req_wdata[0] = 8'h77;
        wait_accept(0, ok);
        req_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("arst_ready[%0d]", i), req_ready[i], 1);
            chk($sformatf("arst_valid[%0d]", i), rsp_valid[i], 0);
            chk($sformatf("arst_rdata[%0d]", i), rsp_rdata[i], 8'h00);
            chk($sformatf("arst_write[%0d]", i), rsp_write[i], 0);
            chk($sformatf("arst_stall[%0d]", i), stall[i], 0);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        do_req(0, 1'b0, 8'h05, 8'h00, 8'h05, lat, rd, rw);
        chk("arst_load05", rd, 8'h00);

        // Latency extremes.
        do_req(1, 1'b1, 8'h80, 8'hC3, 8'h80, lat, rd, rw);
        chk("l1_store_lat", lat, 1);
        do_req(1, 1'b0, 8'h80, 8'h00, 8'h80, lat, rd, rw);
        chk("l1_load_lat", lat, 1);
        chk("l1_load_rdata", rd, 8'hC3);
        do_req(2, 1'b1, 8'h80, 8'hC3, 8'h80, lat, rd, rw);
        chk("l15_store_lat", lat, 15);
        do_req(2, 1'b0, 8'h80, 8'h00, 8'h80, lat, rd, rw);
        chk("l15_load_lat", lat, 15);
        chk("l15_load_rdata", rd, 8'hC3);

        fork
            rand_run(0, 60);
            rand_run(1, 60);
            rand_run(2, 30);
        join

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
